// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: halt states, port ids and
// access-size encodings.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_st_t;

   typedef enum logic {PORT_C = 1'b0, PORT_D = 1'b1} port_t;

   typedef logic [1:0] dtype_t;

   localparam dtype_t BYTE = 2'd0;
   localparam dtype_t HALF = 2'd1;
   localparam dtype_t WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer port wins contention until it has
// taken MAX_BURST back-to-back contended grants, then priority flips.
module rr_arb2
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       freeze,
   input  logic       resume,
   output logic [1:0] gnt
);

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   port_t      ptr;
   logic [3:0] burst_cnt;
   logic [1:0] elig;

   assign elig = req & ~mask;

   always_comb begin
      gnt = 2'b00;
      case (elig)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (ptr == PORT_C) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Under contention the pointer port is always the one granted, so the
   // count only needs to track contended grants to the pointer port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= PORT_C;
         burst_cnt <= '0;
      end else if (resume) begin
         ptr       <= PORT_C;
         burst_cnt <= '0;
      end else if (freeze) begin
         burst_cnt <= '0;
      end else if (elig == 2'b11) begin
         if (burst_cnt == BURST_LAST) begin
            ptr       <= (ptr == PORT_C) ? PORT_D : PORT_C;
            burst_cnt <= '0;
         end else begin
            burst_cnt <= burst_cnt + 4'd1;
         end
      end else if (elig != 2'b00) begin
         burst_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core LSU memory port with a debug master: round-robin arbitration,
// 1-cycle read return routing and a halt sequencer for exclusive debug access.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_c_req,
   input  logic          i_c_wren,
   input  logic [AW-1:0] i_c_addr,
   input  logic [DW-1:0] i_c_wdata,
   input  logic [1:0]    i_c_type,
   input  logic          i_c_unsigned,
   output logic          o_c_gnt,
   output logic          o_c_rvld,
   output logic [DW-1:0] o_c_rdata,
   input  logic          i_d_req,
   input  logic          i_d_wren,
   input  logic [AW-1:0] i_d_addr,
   input  logic [DW-1:0] i_d_wdata,
   input  logic [1:0]    i_d_type,
   input  logic          i_d_unsigned,
   output logic          o_d_gnt,
   output logic          o_d_rvld,
   output logic [DW-1:0] o_d_rdata,
   input  logic          i_dbg_halt,
   output logic          o_c_halted,
   output logic          o_mem_en,
   output logic          o_mem_wren,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   output logic [1:0]    o_mem_type,
   output logic          o_mem_unsigned,
   input  logic [DW-1:0] i_mem_rdata
);

   // Field widths follow the module parameters, so the request layout is local.
   typedef struct packed {
      logic          wren;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      dtype_t        dtype;
      logic          uns;
   } req_t;

   halt_st_t      state;
   logic          rd_pend;
   port_t         rd_owner;
   logic [1:0]    req, mask, gnt;
   logic          c_block, resume;
   req_t          c_req_s, d_req_s, sel;
   logic [DW-1:0] c_rdata_q, d_rdata_q;

   // Core is held off from the cycle halt rises until the cycle after RUN resumes.
   assign c_block = (state != RUN) || i_dbg_halt;
   assign resume  = (state != RUN) && !i_dbg_halt;
   assign req     = {i_d_req, i_c_req};
   assign mask    = {~i_rst_n, ~i_rst_n | c_block};

   rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .req    (req),
      .mask   (mask),
      .freeze (state == HALTED),
      .resume (resume),
      .gnt    (gnt)
   );

   assign c_req_s = {i_c_wren, i_c_addr, i_c_wdata, i_c_type, i_c_unsigned};
   assign d_req_s = {i_d_wren, i_d_addr, i_d_wdata, i_d_type, i_d_unsigned};

   always_comb begin
      sel = '0;
      if (gnt[0])      sel = c_req_s;
      else if (gnt[1]) sel = d_req_s;
   end

   assign o_c_gnt        = gnt[0];
   assign o_d_gnt        = gnt[1];
   assign o_mem_en       = |gnt;
   assign o_mem_wren     = sel.wren;
   assign o_mem_addr     = sel.addr;
   assign o_mem_wdata    = sel.wdata;
   assign o_mem_type     = sel.dtype;
   assign o_mem_unsigned = sel.uns;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_pend   <= 1'b0;
         rd_owner  <= PORT_C;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         rd_pend <= o_mem_en && !sel.wren;
         if (o_mem_en) rd_owner <= gnt[1] ? PORT_D : PORT_C;
         c_rdata_q <= o_c_rdata;
         d_rdata_q <= o_d_rdata;
      end
   end

   assign o_c_rvld  = rd_pend && (rd_owner == PORT_C);
   assign o_d_rvld  = rd_pend && (rd_owner == PORT_D);
   assign o_c_rdata = o_c_rvld ? i_mem_rdata : c_rdata_q;
   assign o_d_rdata = o_d_rvld ? i_mem_rdata : d_rdata_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= RUN;
         o_c_halted <= 1'b0;
      end else begin
         case (state)
            RUN: if (i_dbg_halt) state <= DRAIN;
            DRAIN: begin
               if (!i_dbg_halt) begin
                  state <= RUN;
               end else if (!rd_pend || rd_owner == PORT_D) begin
                  state      <= HALTED;
                  o_c_halted <= 1'b1;
               end
            end
            HALTED: begin
               if (!i_dbg_halt) begin
                  state      <= RUN;
                  o_c_halted <= 1'b0;
               end
            end
            default: begin
               state      <= RUN;
               o_c_halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level reference of the arbitration and halt rules.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int MB = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          i_clk = 1'b0, i_rst_n = 1'b0;
   logic          i_c_req = 0, i_c_wren = 0, i_c_unsigned = 0;
   logic [AW-1:0] i_c_addr = '0;
   logic [DW-1:0] i_c_wdata = '0;
   logic [1:0]    i_c_type = '0;
   logic          i_d_req = 0, i_d_wren = 0, i_d_unsigned = 0;
   logic [AW-1:0] i_d_addr = '0;
   logic [DW-1:0] i_d_wdata = '0;
   logic [1:0]    i_d_type = '0;
   logic          i_dbg_halt = 0;
   logic [DW-1:0] i_mem_rdata = '0;

   logic          o_c_gnt, o_c_rvld, o_d_gnt, o_d_rvld, o_c_halted;
   logic [DW-1:0] o_c_rdata, o_d_rdata, o_mem_wdata;
   logic          o_mem_en, o_mem_wren, o_mem_unsigned;
   logic [AW-1:0] o_mem_addr;
   logic [1:0]    o_mem_type;

   logic          b1_c_gnt, b1_c_rvld, b1_d_gnt, b1_d_rvld, b1_c_halted;
   logic [DW-1:0] b1_c_rdata, b1_d_rdata, b1_mem_wdata;
   logic          b1_mem_en, b1_mem_wren, b1_mem_unsigned;
   logic [AW-1:0] b1_mem_addr;
   logic [1:0]    b1_mem_type;

   int n_chk = 0;
   int n_fail = 0;

   always #5 i_clk = ~i_clk;

   mem_port_arbiter #(.MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_c_req(i_c_req), .i_c_wren(i_c_wren), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
      .i_c_type(i_c_type), .i_c_unsigned(i_c_unsigned),
      .o_c_gnt(o_c_gnt), .o_c_rvld(o_c_rvld), .o_c_rdata(o_c_rdata),
      .i_d_req(i_d_req), .i_d_wren(i_d_wren), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
      .i_d_type(i_d_type), .i_d_unsigned(i_d_unsigned),
      .o_d_gnt(o_d_gnt), .o_d_rvld(o_d_rvld), .o_d_rdata(o_d_rdata),
      .i_dbg_halt(i_dbg_halt), .o_c_halted(o_c_halted),
      .o_mem_en(o_mem_en), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_type(o_mem_type), .o_mem_unsigned(o_mem_unsigned),
      .i_mem_rdata(i_mem_rdata)
   );

   // Second instance with a burst cap of one, fed the same stimulus.
   mem_port_arbiter #(.MAX_BURST(1), .AW(AW), .DW(DW)) dut_b1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_c_req(i_c_req), .i_c_wren(i_c_wren), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
      .i_c_type(i_c_type), .i_c_unsigned(i_c_unsigned),
      .o_c_gnt(b1_c_gnt), .o_c_rvld(b1_c_rvld), .o_c_rdata(b1_c_rdata),
      .i_d_req(i_d_req), .i_d_wren(i_d_wren), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
      .i_d_type(i_d_type), .i_d_unsigned(i_d_unsigned),
      .o_d_gnt(b1_d_gnt), .o_d_rvld(b1_d_rvld), .o_d_rdata(b1_d_rdata),
      .i_dbg_halt(i_dbg_halt), .o_c_halted(b1_c_halted),
      .o_mem_en(b1_mem_en), .o_mem_wren(b1_mem_wren), .o_mem_addr(b1_mem_addr),
      .o_mem_wdata(b1_mem_wdata), .o_mem_type(b1_mem_type), .o_mem_unsigned(b1_mem_unsigned),
      .i_mem_rdata(i_mem_rdata)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      @(negedge i_clk);
   endtask

   task automatic idle();
      i_c_req = 0; i_c_wren = 0; i_d_req = 0; i_d_wren = 0; i_dbg_halt = 0;
   endtask

   task automatic test_reset();
      logic [137:0] outs;
      i_rst_n = 0; i_c_req = 1; i_d_req = 1; i_c_addr = 32'h44; i_d_addr = 32'h88;
      settle();
      outs = {o_c_gnt, o_d_gnt, o_c_rvld, o_d_rvld, o_c_halted, o_mem_en, o_mem_wren,
              o_mem_type, o_mem_unsigned, o_mem_addr, o_mem_wdata, o_c_rdata, o_d_rdata};
      n_chk++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      tick();
      idle();
      i_rst_n = 1;
   endtask

   task automatic test_core_load();
      tick();
      idle();
      i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h0000_0010; i_c_type = WORD;
      settle();
      n_chk++;
      if ({o_c_gnt, o_d_gnt, o_mem_en, o_mem_wren, o_mem_addr} !== {4'b1010, 32'h10}) begin
         n_fail++;
         $display("FAIL core_load_issue: got gnt=%b%b en=%b wr=%b addr=%h want 1010 addr=10",
                  o_c_gnt, o_d_gnt, o_mem_en, o_mem_wren, o_mem_addr);
      end
      tick();
      i_c_req = 0; i_mem_rdata = 32'hDEAD_BEEF;
      settle();
      n_chk++;
      if ({o_c_rvld, o_d_rvld, o_c_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL core_load_return: got rvld=%b%b data=%h want 10 deadbeef",
                  o_c_rvld, o_d_rvld, o_c_rdata);
      end
      tick();
      i_mem_rdata = 32'h0;
      settle();
      n_chk++;
      if ({o_c_rvld, o_c_rdata, o_mem_en} !== {1'b0, 32'hDEAD_BEEF, 1'b0}) begin
         n_fail++;
         $display("FAIL core_load_hold: got rvld=%b data=%h en=%b want 0 deadbeef 0",
                  o_c_rvld, o_c_rdata, o_mem_en);
      end
   endtask

   task automatic test_contention();
      string seq = "CCCCDDDDC";
      tick();
      i_c_req = 1; i_c_wren = 1; i_d_req = 1; i_d_wren = 1;
      for (int k = 0; k < 9; k++) begin
         logic [1:0] want, want_b1;
         want    = (seq[k] == "C") ? 2'b01 : 2'b10;
         want_b1 = (k % 2 == 0) ? 2'b01 : 2'b10;
         settle();
         n_chk++;
         if ({o_d_gnt, o_c_gnt, o_mem_en} !== {want, 1'b1}) begin
            n_fail++;
            $display("FAIL contention_c%0d: got dc=%b%b en=%b want dc=%b en=1",
                     k, o_d_gnt, o_c_gnt, o_mem_en, want);
         end
         n_chk++;
         if ({b1_d_gnt, b1_c_gnt} !== want_b1) begin
            n_fail++;
            $display("FAIL burst1_alternate_c%0d: got dc=%b%b want %b", k, b1_d_gnt, b1_c_gnt, want_b1);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_alt_reads();
      tick();
      i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h10;
      settle();
      n_chk++;
      if ({o_c_gnt, o_mem_addr} !== {1'b1, 32'h10}) begin
         n_fail++; $display("FAIL alt_c_issue: got gnt=%b addr=%h want 1 10", o_c_gnt, o_mem_addr);
      end
      tick();
      i_c_req = 0; i_d_req = 1; i_d_wren = 0; i_d_addr = 32'h20; i_mem_rdata = 32'h11;
      settle();
      n_chk++;
      if ({o_c_rvld, o_d_rvld, o_c_rdata, o_d_gnt, o_mem_addr} !== {2'b10, 32'h11, 1'b1, 32'h20}) begin
         n_fail++;
         $display("FAIL alt_c_return: got rvld=%b%b cdata=%h dgnt=%b addr=%h want 10 11 1 20",
                  o_c_rvld, o_d_rvld, o_c_rdata, o_d_gnt, o_mem_addr);
      end
      tick();
      i_d_req = 0; i_mem_rdata = 32'h22;
      settle();
      n_chk++;
      if ({o_c_rvld, o_d_rvld, o_d_rdata, o_c_rdata} !== {2'b01, 32'h22, 32'h11}) begin
         n_fail++;
         $display("FAIL alt_d_return: got rvld=%b%b ddata=%h cdata=%h want 01 22 11",
                  o_c_rvld, o_d_rvld, o_d_rdata, o_c_rdata);
      end
   endtask

   task automatic test_halt();
      bit seen;
      tick();
      idle();
      i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h30;
      settle();
      n_chk++;
      if (o_c_gnt !== 1'b1) begin
         n_fail++; $display("FAIL halt_pre_grant: got %b want 1", o_c_gnt);
      end
      tick();
      i_dbg_halt = 1; i_mem_rdata = 32'hCAFE_F00D;
      settle();
      n_chk++;
      if ({o_c_gnt, o_mem_en, o_c_rvld, o_c_rdata} !== {3'b001, 32'hCAFE_F00D}) begin
         n_fail++;
         $display("FAIL halt_drain_return: got gnt=%b en=%b rvld=%b data=%h want 0 0 1 cafef00d",
                  o_c_gnt, o_mem_en, o_c_rvld, o_c_rdata);
      end
      seen = 0;
      for (int k = 0; k < 2 && !seen; k++) begin
         tick();
         settle();
         n_chk++;
         if (o_c_gnt !== 1'b0) begin
            n_fail++; $display("FAIL halt_core_blocked_%0d: got %b want 0", k, o_c_gnt);
         end
         seen = (o_c_halted === 1'b1);
      end
      n_chk++;
      if (!seen) begin
         n_fail++; $display("FAIL halt_reached: o_c_halted=%b after 2 cycles, want 1", o_c_halted);
      end
      tick();
      i_d_req = 1; i_d_wren = 1; i_d_addr = 32'h40; i_d_wdata = 32'h5;
      settle();
      n_chk++;
      if ({o_c_gnt, o_d_gnt, o_mem_wren, o_mem_addr, o_mem_wdata} !== {3'b011, 32'h40, 32'h5}) begin
         n_fail++;
         $display("FAIL halt_d_write: got cd=%b%b wr=%b addr=%h wd=%h want 01 1 40 5",
                  o_c_gnt, o_d_gnt, o_mem_wren, o_mem_addr, o_mem_wdata);
      end
   endtask

   task automatic test_release();
      tick();
      i_c_req = 1; i_c_wren = 1; i_d_req = 1; i_d_wren = 1; i_dbg_halt = 0;
      settle();
      n_chk++;
      if ({o_c_halted, o_c_gnt, o_d_gnt} !== 3'b101) begin
         n_fail++;
         $display("FAIL release_cycle: got halted=%b cd=%b%b want 1 01", o_c_halted, o_c_gnt, o_d_gnt);
      end
      tick();
      settle();
      n_chk++;
      if ({o_c_halted, o_c_gnt, o_d_gnt} !== 3'b010) begin
         n_fail++;
         $display("FAIL release_resume: got halted=%b cd=%b%b want 0 10", o_c_halted, o_c_gnt, o_d_gnt);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid_read();
      logic [137:0] outs;
      tick();
      i_d_req = 1; i_d_wren = 0; i_d_addr = 32'h50;
      settle();
      n_chk++;
      if (o_d_gnt !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_d_grant: got %b want 1", o_d_gnt);
      end
      tick();
      i_rst_n = 0; i_c_req = 1; i_c_wren = 0; i_mem_rdata = 32'h77;
      #1;
      outs = {o_c_gnt, o_d_gnt, o_c_rvld, o_d_rvld, o_c_halted, o_mem_en, o_mem_wren,
              o_mem_type, o_mem_unsigned, o_mem_addr, o_mem_wdata, o_c_rdata, o_d_rdata};
      n_chk++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", outs);
      end
      tick();
      i_rst_n = 1;
      settle();
      n_chk++;
      if ({o_d_rvld, o_c_gnt, o_d_gnt} !== 3'b010) begin
         n_fail++;
         $display("FAIL rst_mid_after: got drvld=%b cd=%b%b want 0 10", o_d_rvld, o_c_gnt, o_d_gnt);
      end
      tick();
      settle();
      n_chk++;
      if (o_d_rvld !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_no_drvld: got %b want 0", o_d_rvld);
      end
      tick();
      idle();
   endtask

   // Reference: the core may be granted only when halt is low now and was low
   // last cycle; halted reads high after halt has been high for two cycles.
   task automatic test_random();
      int            fav, rd_port;
      int            streak[$];
      bit            h1, h2;
      logic [DW-1:0] last_c, last_d;
      i_rst_n = 0;
      idle();
      tick();
      i_rst_n = 1;
      fav = 0; rd_port = -1; h1 = 0; h2 = 0; last_c = '0; last_d = '0;
      for (int k = 0; k < 500; k++) begin
         bit            c_ok, ec, ed, exp_wr;
         logic [AW-1:0] exp_addr;
         logic [DW-1:0] exp_cd, exp_dd;
         tick();
         i_c_req  = ($urandom_range(0, 9) < 6);
         i_d_req  = ($urandom_range(0, 9) < 6);
         i_c_wren = $urandom_range(0, 1) == 1;
         i_d_wren = $urandom_range(0, 1) == 1;
         i_c_addr = $urandom(); i_d_addr = $urandom();
         i_c_type = 2'($urandom_range(0, 2)); i_d_type = 2'($urandom_range(0, 2));
         i_mem_rdata = $urandom();
         if ($urandom_range(0, 99) < 8) i_dbg_halt = ~i_dbg_halt;
         c_ok = i_c_req && !i_dbg_halt && !h1;
         ec = c_ok && (!i_d_req || fav == 0);
         ed = i_d_req && (!c_ok || fav == 1);
         exp_wr   = ec ? i_c_wren : (ed ? i_d_wren : 1'b0);
         exp_addr = ec ? i_c_addr : (ed ? i_d_addr : '0);
         exp_cd   = (rd_port == 0) ? i_mem_rdata : last_c;
         exp_dd   = (rd_port == 1) ? i_mem_rdata : last_d;
         settle();
         n_chk++;
         if ({o_c_gnt, o_d_gnt, o_mem_en, o_mem_wren, o_mem_addr, o_c_halted} !==
             {ec, ed, ec | ed, exp_wr, exp_addr, h1 & h2}) begin
            n_fail++;
            $display("FAIL rand_grant_c%0d: got cd=%b%b en=%b wr=%b addr=%h hl=%b want cd=%b%b wr=%b addr=%h hl=%b",
                     k, o_c_gnt, o_d_gnt, o_mem_en, o_mem_wren, o_mem_addr, o_c_halted,
                     ec, ed, exp_wr, exp_addr, h1 & h2);
         end
         n_chk++;
         if ({o_c_rvld, o_d_rvld, o_c_rdata, o_d_rdata} !==
             {rd_port == 0, rd_port == 1, exp_cd, exp_dd}) begin
            n_fail++;
            $display("FAIL rand_return_c%0d: got rvld=%b%b c=%h d=%h want port=%0d c=%h d=%h",
                     k, o_c_rvld, o_d_rvld, o_c_rdata, o_d_rdata, rd_port, exp_cd, exp_dd);
         end
         last_c = exp_cd; last_d = exp_dd;
         rd_port = (ec && !i_c_wren) ? 0 : ((ed && !i_d_wren) ? 1 : -1);
         if (h1 && !i_dbg_halt) begin
            fav = 0; streak.delete();
         end else if (c_ok && i_d_req) begin
            streak.push_back(fav);
            if (streak.size() == MB) begin
               fav = 1 - fav; streak.delete();
            end
         end else if (ec || ed) begin
            streak.delete();
         end
         h2 = h1; h1 = i_dbg_halt;
      end
      tick();
      idle();
   endtask

   initial begin
      test_reset();
      test_core_load();
      test_contention();
      test_alt_reads();
      test_halt();
      test_release();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory/LSU port of the single-cycle core between two requesters: the core load/store path (port C) and a debug/program-loader master (port D).
- Memory side has 1-cycle synchronous read latency.
- Grants at most one access per cycle. Arbitration is round-robin with a burst cap.
- Includes a debug-halt sequencer that drains the core's in-flight read and then gives port D exclusive access.

Parameters:
- MAX_BURST, 4, max consecutive grants to one port while the other is requesting (range 1..15).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_c_req  in  1  core access request
- i_c_wren  in  1  core write (1) / read (0)
- i_c_addr  in  AW  core address
- i_c_wdata  in  DW  core store data
- i_c_type  in  2  core data type (byte/half/word)
- i_c_unsigned  in  1  core unsigned load
- o_c_gnt  out  1  core request accepted this cycle (low = core stalls)
- o_c_rvld  out  1  core read data valid
- o_c_rdata  out  DW  core read data
- i_d_req, i_d_wren, i_d_addr, i_d_wdata, i_d_type, i_d_unsigned  in  1/1/AW/DW/2/1  debug master request fields, same meaning as the core fields
- o_d_gnt, o_d_rvld  out  1  debug grant / read valid
- o_d_rdata  out  DW  debug read data
- i_dbg_halt  in  1  level request for exclusive debug ownership
- o_c_halted  out  1  core is held off and memory is exclusively debug-owned
- o_mem_en  out  1  memory access this cycle
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory store data
- o_mem_type  out  2  memory data type
- o_mem_unsigned  out  1  memory unsigned load
- i_mem_rdata  in  DW  memory read data, valid 1 cycle after a read is issued

Behaviour:
- Reset (async, i_rst_n=0): halt FSM=RUN, priority pointer=C, burst_cnt=0, rd_pend=0, rd_owner=C. All outputs 0; rdata outputs are 0.
- Grant is combinational from the current requests and registered state. Exactly zero or one of o_c_gnt/o_d_gnt is high.
- o_mem_* mux the granted port's fields. o_mem_en = o_c_gnt | o_d_gnt. When neither port is granted, o_mem_wren=0.
- Arbitration in RUN:
  - Only one port requesting: that port is granted.
  - Both requesting: the pointer port is granted.
  - After every grant, the pointer moves to the other port if burst_cnt+1 == MAX_BURST while the other port is requesting. Otherwise the pointer stays.
  - burst_cnt increments on a repeat grant to the same port. It resets to 0 on a switch, or when the other port is not requesting.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=port (registered).
  - Next cycle, that port's rvld=1 and its rdata=i_mem_rdata. The other port's rdata is held at its last value.
  - Writes produce no rvld.
  - Back-to-back reads from alternating ports give each port correctly routed rvld in consecutive cycles.
- Halt FSM:
  - RUN -> DRAIN when i_dbg_halt=1. The core is not granted from that cycle on.
  - DRAIN: the core gets no grants; port D is still arbitrated normally. Go to HALTED when no core read is pending (rd_pend=0 or rd_owner=D). DRAIN lasts at most 1 cycle.
  - HALTED: o_c_halted=1 (registered). Only port D is granted. burst_cnt is frozen at 0.
  - HALTED or DRAIN -> RUN when i_dbg_halt=0. On entering RUN the pointer is set to C so the core resumes first.
- Boundaries:
  - Core request arriving in the same cycle halt rises: not granted.
  - Halt deasserted in DRAIN: return to RUN with no stuck state.
  - No request from either port: o_mem_en=0, and pointer and burst_cnt are unchanged.
  - MAX_BURST=1: strict alternation under contention.
  - Reset mid-read: pending rvld is dropped; no rvld after reset release.

Decomposition:
- Shared package: halt state enum (RUN, DRAIN, HALTED), port-id typedef (PORT_C, PORT_D), data-type constants (BYTE=0, HALF=1, WORD=2), request struct {wren, addr, wdata, type, unsigned}.
- One sub-module, rr_arb2: 2-way round-robin with burst counter. Inputs: req[1:0], mask[1:0]. Outputs: gnt[1:0]. Holds pointer and burst_cnt.
- Halt FSM, request mux and read-return routing live in the top.

Test Plan:
- Core-only load, addr 0x0000_0010, mem returns 0xDEAD_BEEF -> c_gnt=1 in cycle 0; c_rvld=1 and c_rdata=0xDEADBEEF in cycle 1; d_rvld=0.
- Both ports request continuously, MAX_BURST=4 -> grant sequence C,C,C,C,D,D,D,D,C; o_mem_en=1 every cycle.
- Alternating reads C@0x10 then D@0x20, mem data 0x11 then 0x22 -> c_rvld with 0x11, then d_rvld with 0x22, each exactly 1 cycle after its grant.
- Core read granted, then i_dbg_halt=1 next cycle -> core rvld still delivered; c_gnt=0 from halt cycle; o_c_halted=1 within 2 cycles; D writes 0x5 to 0x40 with o_mem_wren=1.
- Release halt with both requesting -> o_c_halted=0 next cycle, first grant goes to C.
- Assert i_rst_n=0 one cycle after a D read grant -> all outputs 0 immediately; no d_rvld after release; first post-reset contention grants C.
